ps2_kb_code: RTL and testbench

Upstream stage of the PS2 keyboard path: consumes raw scan-code bytes from the PS2 receiver and extracts one key code per key release by parsing the make/break (`F0`) and extended (`E0`) prefixes. Completed codes sit in a small first-word-fall-through FIFO. The downstream scan-to-ASCII stage and its consumer drain the FIFO with a read strobe, so the UART/display logic can read keys at its own pace.

---
 rtl/ps2_kb_code_if.sv | 24 ++
 rtl/ps2_kb_code.sv | 189 ++++++++++++++++++
 tb/tb_ps2_kb_code.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kb_code_if.sv
// Bundles the scan-byte input, the FIFO read strobe and the key-code FIFO outputs.
// master: the driving side (PS2 receiver plus downstream reader); slave: ps2_kb_code.
// Clock and reset are plain ports on the module, not part of this bundle.
interface ps2_kb_code_if;
    logic [7:0] i_rx_data;
    logic       i_rx_done_tick;
    logic       i_rd;
    logic [7:0] o_key_code;
    logic       o_ext;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
    logic       o_shift;

    modport master (
        output i_rx_data, i_rx_done_tick, i_rd,
        input  o_key_code, o_ext, o_empty, o_full, o_overflow, o_shift
    );

    modport slave (
        input  i_rx_data, i_rx_done_tick, i_rd,
        output o_key_code, o_ext, o_empty, o_full, o_overflow, o_shift
    );
endinterface

// File: rtl/ps2_kb_code.sv
// Parses PS2 scan bytes (F0 break / E0 extended prefixes) into one {ext, code} per key release, queued in a FWFT FIFO.
// Latency: final break byte on cycle N -> head valid and o_empty=0 on cycle N+1; i_rd on N -> next head on N+1.
// Backpressure: none upstream; a release arriving while full (and no same-cycle read) is dropped and sets sticky o_overflow.
// Optional build macro PS2_KB_SHIFT_EN: tracks held left/right shift and keeps shift releases out of the FIFO.

// Generic synchronous first-word-fall-through FIFO with registered flags.
module ps2_kb_fifo #(
    parameter int AW = 2,
    parameter int W  = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW-1:0] rd_ptr_nxt;
    logic          do_pop;
    logic          do_push;

    // Pop needs data; push while full only succeeds if a pop frees the slot in the same cycle.
    always_comb begin
        wr_ptr_nxt = wr_ptr + AW'(1);
        rd_ptr_nxt = rd_ptr + AW'(1);
        do_pop     = pop_rdy && !empty;
        do_push    = push_vld && (!full || do_pop);
    end

    assign head_dat = mem[rd_ptr];

    // Storage, pointers and flags all advance together on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr_nxt;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (do_push && !do_pop) begin
                empty <= 1'b0;
                full  <= (wr_ptr_nxt == rd_ptr);
            end else if (do_pop && !do_push) begin
                full  <= 1'b0;
                empty <= (rd_ptr_nxt == wr_ptr);
            end
        end
    end
endmodule

module ps2_kb_code #(
    parameter int         FIFO_ADDR_W = 2,
    parameter logic [7:0] BRK_CODE    = 8'hF0,
    parameter logic [7:0] EXT_CODE    = 8'hE0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    ps2_kb_code_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK} state_t;

    state_t     state;
    logic       ext_q;
    logic       byte_brk;
    logic       byte_ext;
    logic       release_vld;
    logic       push_vld;
    logic [8:0] head_dat;

`ifdef PS2_KB_SHIFT_EN
    logic shift_l;
    logic shift_r;
    logic shift_key;

    // A non-extended 12/59 is a shift key; its release only updates the held bits.
    always_comb begin
        shift_key = !ext_q && (bus.i_rx_data == 8'h12 || bus.i_rx_data == 8'h59);
    end
`endif

    // Classify the incoming byte and decide whether it completes a release.
    always_comb begin
        byte_brk    = (bus.i_rx_data == BRK_CODE);
        byte_ext    = (bus.i_rx_data == EXT_CODE);
        release_vld = bus.i_rx_done_tick && (state == S_BRK) && !byte_brk && !byte_ext;
`ifdef PS2_KB_SHIFT_EN
        push_vld    = release_vld && !shift_key;
`else
        push_vld    = release_vld;
`endif
    end

    // Prefix parser: only bytes with a done tick move the state or the ext flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            ext_q <= 1'b0;
        end else if (bus.i_rx_done_tick) begin
            case (state)
                S_IDLE: begin
                    if (byte_brk) begin
                        state <= S_BRK;
                        ext_q <= 1'b0;
                    end else if (byte_ext) begin
                        state <= S_EXT;
                    end
                end
                S_EXT: begin
                    if (byte_brk) begin
                        state <= S_BRK;
                        ext_q <= 1'b1;
                    end else if (!byte_ext) begin
                        state <= S_IDLE;
                    end
                end
                S_BRK: begin
                    if (!byte_brk && !byte_ext) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PS2_KB_SHIFT_EN
    // Held-shift tracking: plain makes set, plain breaks clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (bus.i_rx_done_tick && !byte_brk && !byte_ext) begin
            if (state == S_IDLE) begin
                if (bus.i_rx_data == 8'h12) shift_l <= 1'b1;
                if (bus.i_rx_data == 8'h59) shift_r <= 1'b1;
            end else if (state == S_BRK && !ext_q) begin
                if (bus.i_rx_data == 8'h12) shift_l <= 1'b0;
                if (bus.i_rx_data == 8'h59) shift_r <= 1'b0;
            end
        end
    end

    assign bus.o_shift = shift_l | shift_r;
`else
    assign bus.o_shift = 1'b0;
`endif

    // Sticky overflow: a release was lost because the FIFO was full and not being read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_overflow <= 1'b0;
        end else if (push_vld && bus.o_full && !bus.i_rd) begin
            bus.o_overflow <= 1'b1;
        end
    end

    ps2_kb_fifo #(
        .AW (FIFO_ADDR_W),
        .W  (9)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push_vld (push_vld),
        .push_dat ({ext_q, bus.i_rx_data}),
        .pop_rdy  (bus.i_rd),
        .head_dat (head_dat),
        .empty    (bus.o_empty),
        .full     (bus.o_full)
    );

    assign bus.o_ext      = head_dat[8];
    assign bus.o_key_code = head_dat[7:0];
endmodule

// File: tb/tb_ps2_kb_code.sv
// Self-checking bench for ps2_kb_code: table of scan sequences with a scoreboard of expected releases,
// plus hand-written sequences for overflow, simultaneous read/write, mid-sequence reset and shift tracking.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_ps2_kb_code;
    logic i_clk;
    logic i_reset;

    ps2_kb_code_if ifc ();

    ps2_kb_code #(
        .FIFO_ADDR_W (2),
        .BRK_CODE    (8'hF0),
        .EXT_CODE    (8'hE0)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (ifc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          n;
        logic [39:0] seq;      // first byte in [39:32]
        logic        exp_push;
        logic        exp_ext;
        logic [7:0]  exp_code;
    } vec_t;

    int         total  = 0;
    int         passed = 0;
    logic [8:0] sb [$];
    vec_t       vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int n, input logic [39:0] seq, input logic p,
                                input logic e, input logic [7:0] c);
        vec_t v;
        v.n = n; v.seq = seq; v.exp_push = p; v.exp_ext = e; v.exp_code = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        sb.delete();
    endtask

    // One byte per cycle, no gaps between consecutive bytes.
    task automatic send_seq(input int n, input logic [39:0] seq);
        for (int j = 0; j < n; j++) begin
            ifc.i_rx_data      = seq[39 - 8*j -: 8];
            ifc.i_rx_done_tick = 1'b1;
            tick();
        end
        ifc.i_rx_done_tick = 1'b0;
        ifc.i_rx_data      = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_seq(1, {b, 32'h0});
    endtask

    // Pops every entry the DUT holds, comparing each head against the scoreboard.
    task automatic drain(input string name);
        int budget = 16;
        while (!ifc.o_empty && budget > 0) begin
            chk({name, "_sb_has_entry"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                chk({name, "_head"}, {ifc.o_ext, ifc.o_key_code}, sb.pop_front());
            end
            ifc.i_rd = 1'b1;
            tick();
            ifc.i_rd = 1'b0;
            budget--;
        end
        chk({name, "_empty"}, ifc.o_empty, 1);
        chk({name, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        logic [7:0] keys [5];
        logic [7:0] shseq [6];
        logic       shexp [6];

        i_reset            = 1'b1;
        ifc.i_rx_data      = 8'h00;
        ifc.i_rx_done_tick = 1'b0;
        ifc.i_rd           = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;

        chk("rst_code", ifc.o_key_code, 8'h00);
        chk("rst_ext", ifc.o_ext, 0);
        chk("rst_empty", ifc.o_empty, 1);
        chk("rst_full", ifc.o_full, 0);
        chk("rst_ovf", ifc.o_overflow, 0);
        chk("rst_shift", ifc.o_shift, 0);

        // ---------------- table-driven sequences ----------------
        vecs[0] = mk(3, 40'h1CF01C0000, 1, 0, 8'h1C);
        vecs[1] = mk(5, 40'hE075E0F075, 1, 1, 8'h75);
        vecs[2] = mk(3, 40'h1C1C1C0000, 0, 0, 8'h00);   // typematic repeat
        vecs[3] = mk(3, 40'hF0F02A0000, 1, 0, 8'h2A);   // repeated F0 stays in break
        vecs[4] = mk(5, 40'hE0E0F0E04A, 1, 1, 8'h4A);   // E0 inside break keeps ext
        vecs[5] = mk(2, 40'hE011000000, 0, 0, 8'h00);   // extended make only
        vecs[6] = mk(3, 40'hE0F0110000, 1, 1, 8'h11);
`ifdef PS2_KB_SHIFT_EN
        vecs[7] = mk(2, 40'hF012000000, 0, 0, 8'h12);   // shift release not queued
`else
        vecs[7] = mk(2, 40'hF012000000, 1, 0, 8'h12);
`endif
        vecs[8] = mk(3, 40'h5AF05A0000, 1, 0, 8'h5A);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].exp_push) sb.push_back({vecs[i].exp_ext, vecs[i].exp_code});
            send_seq(vecs[i].n, vecs[i].seq);
            chk($sformatf("v%0d_vld_next_cycle", i), ifc.o_empty, !vecs[i].exp_push);
            drain($sformatf("v%0d", i));
        end

        // ---------------- overflow: five releases into a four-deep FIFO ----------------
        keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back({1'b0, keys[i]});
            send_seq(2, {8'hF0, keys[i], 24'h0});
        end
        chk("ovf_full", ifc.o_full, 1);
        chk("ovf_flag", ifc.o_overflow, 1);
        chk("ovf_head_first", ifc.o_key_code, 8'h15);
        drain("ovf");
        chk("ovf_sticky", ifc.o_overflow, 1);

        // ---------------- release while full with a same-cycle read ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b0, keys[i]});
            send_seq(2, {8'hF0, keys[i], 24'h0});
        end
        chk("rw_full_before", ifc.o_full, 1);
        send_byte(8'hF0);
        chk("rw_head_before", {ifc.o_ext, ifc.o_key_code}, sb.pop_front());
        sb.push_back({1'b0, 8'h35});
        ifc.i_rx_data      = 8'h35;
        ifc.i_rx_done_tick = 1'b1;
        ifc.i_rd           = 1'b1;
        tick();
        ifc.i_rx_done_tick = 1'b0;
        ifc.i_rd           = 1'b0;
        chk("rw_no_ovf", ifc.o_overflow, 0);
        chk("rw_still_full", ifc.o_full, 1);
        drain("rw");

        // ---------------- reset in the middle of a break sequence ----------------
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        chk("mid_code", ifc.o_key_code, 8'h00);
        chk("mid_ext", ifc.o_ext, 0);
        chk("mid_empty", ifc.o_empty, 1);
        chk("mid_full", ifc.o_full, 0);
        chk("mid_ovf", ifc.o_overflow, 0);
        chk("mid_shift", ifc.o_shift, 0);
        sb.push_back({1'b0, 8'h1C});
        send_seq(2, 40'hF01C000000);
        drain("mid_after");

        // ---------------- shift tracking ----------------
        shseq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
`ifdef PS2_KB_SHIFT_EN
        shexp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        sb.push_back({1'b0, 8'h1C});
`else
        shexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sb.push_back({1'b0, 8'h1C});
        sb.push_back({1'b0, 8'h12});
`endif
        for (int i = 0; i < 6; i++) begin
            send_byte(shseq[i]);
            chk($sformatf("shift_b%0d", i), ifc.o_shift, shexp[i]);
        end
        drain("shift");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
